keccak_word_packer: RTL and testbench

KECCAK_WORD_PACKER -- requirements
Module: keccak_word_packer

---
 rtl/keccak_word_packer_if.sv | 24 ++
 rtl/keccak_word_packer.sv | 123 ++++++++++++
 tb/tb_keccak_word_packer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keccak_word_packer_if.sv
// Byte-in / word-out bus between a byte source, the word packer and the keccak core.
// The slave modport is the packer side; master is the byte source plus the core's word sink.
interface keccak_word_packer_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        buffer_full;
  logic [31:0] in;
  logic        in_ready;
  logic        is_last;
  logic [1:0]  byte_num;
  logic        sent;

  modport slave (
    input  byte_in, byte_valid, byte_last, buffer_full,
    output byte_ready, in, in_ready, is_last, byte_num, sent
  );

  modport master (
    output byte_in, byte_valid, byte_last, buffer_full,
    input  byte_ready, in, in_ready, is_last, byte_num, sent
  );
endinterface

// File: rtl/keccak_word_packer.sv
// Packs a byte stream big-endian into 32-bit words for a keccak core, appending an
// all-zero final word when the message length is a multiple of four.
module keccak_word_packer (
  input  logic                       clk,
  input  logic                       reset,
  keccak_word_packer_if.slave        bus,
  output logic [1:0]                 o_dbg_state
);

  // Handshakes: a byte moves on an edge with byte_valid & byte_ready; a word moves
  // on an edge with in_ready & !buffer_full. Word outputs hold steady while stalled.
  typedef enum logic [1:0] {
    ST_ACCUM    = 2'd0,
    ST_SEND     = 2'd1,
    ST_SEND_PAD = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_pad;
  logic        r_last;
  logic [1:0]  r_num;

  logic        w_accept;
  logic        w_deliver;
  logic        w_word_done;
  logic [31:0] w_word_wr;
  logic        w_byte_ready;
  logic        w_in_ready;
  logic [31:0] w_in;
  logic        w_is_last;
  logic [1:0]  w_byte_num;
  logic        w_sent;

  always_comb begin
    w_state_nxt  = r_state;
    w_byte_ready = 1'b0;
    w_in_ready   = 1'b0;
    w_in         = '0;
    w_is_last    = 1'b0;
    w_byte_num   = '0;
    w_sent       = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_byte_ready = 1'b1;
        if (bus.byte_valid && (bus.byte_last || r_cnt == 2'd3)) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        w_in_ready = 1'b1;
        w_in       = r_word;
        w_is_last  = r_last;
        w_byte_num = r_num;
        if (!bus.buffer_full) begin
          if (r_last)     w_state_nxt = ST_DONE;
          else if (r_pad) w_state_nxt = ST_SEND_PAD;
          else            w_state_nxt = ST_ACCUM;
        end
      end
      ST_SEND_PAD: begin
        w_in_ready = 1'b1;
        w_is_last  = 1'b1;
        if (!bus.buffer_full) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_sent = 1'b1;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // Unwritten lanes stay zero because the word register is cleared on every delivery.
  always_comb begin
    w_word_wr = r_word;
    case (r_cnt)
      2'd0:    w_word_wr[31:24] = bus.byte_in;
      2'd1:    w_word_wr[23:16] = bus.byte_in;
      2'd2:    w_word_wr[15:8]  = bus.byte_in;
      default: w_word_wr[7:0]   = bus.byte_in;
    endcase
  end

  assign w_accept    = (r_state == ST_ACCUM) && bus.byte_valid;
  assign w_deliver   = w_in_ready && !bus.buffer_full;
  assign w_word_done = bus.byte_last || (r_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACCUM;
      r_cnt   <= '0;
      r_word  <= '0;
      r_pad   <= 1'b0;
      r_last  <= 1'b0;
      r_num   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word <= w_word_wr;
        if (w_word_done) begin
          r_cnt  <= '0;
          // A last byte filling lane 3 still needs a separate empty final word.
          r_last <= bus.byte_last && (r_cnt != 2'd3);
          r_pad  <= bus.byte_last && (r_cnt == 2'd3);
          r_num  <= (bus.byte_last && (r_cnt != 2'd3)) ? r_cnt + 2'd1 : 2'd0;
        end else begin
          r_cnt <= r_cnt + 2'd1;
        end
      end
      if (w_deliver) r_word <= '0;
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.in_ready   = w_in_ready;
  assign bus.in         = w_in;
  assign bus.is_last    = w_is_last;
  assign bus.byte_num   = w_byte_num;
  assign bus.sent       = w_sent;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_keccak_word_packer.sv
// Randomized bench for keccak_word_packer: a message-level model predicts every word,
// a negedge monitor scores deliveries and idle outputs against it.
module tb_keccak_word_packer;

  typedef logic [7:0] byte_q_t[$];

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  keccak_word_packer_if bus();

  keccak_word_packer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [34:0] exp_q[$];
  int          bp_pct   = 0;
  logic        bp_force = 1'b1;
  logic        bp_val   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // buffer_full is only ever changed just after a rising edge
  always @(posedge clk) begin
    #1;
    bus.buffer_full = bp_force ? bp_val : ($urandom_range(0, 99) < bp_pct);
  end

  // ---------------- reference model ----------------
  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic void model_push(input byte_q_t m);
    int L  = m.size();
    int nw = L / 4 + 1;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] wd;
      logic        last;
      logic [1:0]  num;
      wd = '0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < L) wd[31 - 8 * k -: 8] = m[4 * w + k];
      last = (w == nw - 1);
      num  = last ? 2'(L - 4 * w) : 2'd0;
      exp_q.push_back({wd, last, num});
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [34:0] obs;
    logic [34:0] e;
    obs = {bus.in, bus.is_last, bus.byte_num};
    if (!reset) begin
      if (bus.in_ready) begin
        if (!bus.buffer_full) begin
          if (exp_q.size() == 0) check("extra_word", 64'(obs) | 64'h1_0000_0000_0, 64'h0);
          else begin
            e = exp_q.pop_front();
            check("word", 64'(obs), 64'(e));
          end
        end
      end else begin
        check("idle_out", 64'(obs), 64'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    bus.byte_in    = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_reset_state();
    check("rst_byte_ready", 64'(bus.byte_ready), 64'd1);
    check("rst_in_ready",   64'(bus.in_ready),   64'd0);
    check("rst_sent",       64'(bus.sent),       64'd0);
    check("rst_outs",       64'({bus.in, bus.is_last, bus.byte_num}), 64'd0);
    check("rst_state",      64'(dbg_state),      64'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    bus.byte_last  = last;
    n = 0;
    @(negedge clk);
    while (!bus.byte_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("byte_accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
  endtask

  task automatic drive_msg(input byte_q_t m, input int gap_pct);
    for (int i = 0; i < m.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) idle($urandom_range(1, 3));
      send_byte(m[i], i == m.size() - 1);
    end
  endtask

  task automatic wait_sent();
    int n;
    n = 0;
    while (!bus.sent && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("sent",       64'(bus.sent),       64'd1);
    check("drain",      64'(exp_q.size()),   64'd0);
    check("done_ready", 64'(bus.byte_ready), 64'd0);
  endtask

  task automatic run_msg(input byte_q_t m, input int gap_pct, input int bp);
    do_reset();
    bp_force = 1'b0;
    bp_pct   = bp;
    model_push(m);
    drive_msg(m, gap_pct);
    wait_sent();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    byte_q_t m;
    reset          = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_last  = 1'b0;
    bus.byte_in    = 8'h00;

    do_reset();
    check_reset_state();

    run_msg(str2q("Hello, world!"), 0, 0);
    run_msg(str2q("Hello, world"), 0, 0);
    m = {8'h41};
    run_msg(m, 0, 0);

    // bytes presented after the final word must be ignored
    bus.byte_valid = 1'b1;
    bus.byte_last  = 1'b1;
    bus.byte_in    = 8'h5A;
    idle(5);
    bus.byte_valid = 1'b0;
    check("done_hold", 64'({bus.sent, dbg_state}), 64'h7);

    // word held under backpressure, then released
    do_reset();
    bp_force = 1'b1;
    bp_val   = 1'b1;
    model_push(str2q("abcde"));
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("stall_word",  64'({bus.in, bus.is_last, bus.byte_num}), 64'({32'h61626364, 1'b0, 2'd0}));
      check("stall_ready", 64'({bus.in_ready, bus.byte_ready}), 64'h2);
    end
    bp_val = 1'b0;
    @(posedge clk);
    #1;
    send_byte(8'h65, 1'b1);
    wait_sent();

    // reset abandons a stalled word
    do_reset();
    bp_force = 1'b1;
    bp_val   = 1'b1;
    send_byte(8'h77, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h79, 1'b0);
    send_byte(8'h7A, 1'b0);
    @(negedge clk);
    check("pend_before_rst", 64'(bus.in_ready), 64'd1);
    do_reset();
    bp_val = 1'b0;
    check_reset_state();
    bp_force = 1'b0;
    bp_pct   = 0;
    model_push(str2q("abc"));
    drive_msg(str2q("abc"), 0);
    wait_sent();

    run_msg(str2q("The quick"), 60, 0);

    for (int t = 0; t < 12; t++) begin
      int L;
      m.delete();
      L = $urandom_range(1, 20);
      for (int i = 0; i < L; i++) m.push_back(8'($urandom_range(0, 255)));
      run_msg(m, 30, 40);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
